// File: rtl/pitch_table_writer.sv
// Pitch table writer: loads the 16-bit pitch phase-delta table RAM from a
// valid/ready byte stream, packing little-endian byte pairs into words.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           one-cycle request to begin a load (ignored while busy)
//   i_byte_valid      byte source has data
//   i_byte[7:0]       data byte
//   o_byte_ready      byte accepted on an edge where valid && ready
//   o_ram_we          one-cycle write strobe per word
//   o_ram_addr        word address, qualified by o_ram_we
//   o_ram_data        word data, qualified by o_ram_we
//   o_busy            load in progress
//   o_done            one-cycle pulse at end of load
//   o_error           sticky checksum mismatch flag
//
// Optional build macro PITCH_TABLE_WRITER_CHECKSUM_EN adds a trailing
// XOR checksum byte (CHK state); without it o_error is tied low.

module pitch_table_writer #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_byte_ready,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [15:0]       o_ram_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    WR,
`ifdef PITCH_TABLE_WRITER_CHECKSUM_EN
    CHK,
`endif
    FIN
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] addr;
  logic [7:0]        lo_byte;
  logic              accept;

  assign accept = i_byte_valid && o_byte_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (i_start) state_n = LO;
      LO:   if (accept)  state_n = HI;
      HI:   if (accept)  state_n = WR;
      WR: begin
        if (addr == LAST) begin
`ifdef PITCH_TABLE_WRITER_CHECKSUM_EN
          state_n = CHK;
`else
          state_n = FIN;
`endif
        end else begin
          state_n = LO;
        end
      end
`ifdef PITCH_TABLE_WRITER_CHECKSUM_EN
      CHK:  if (accept)  state_n = FIN;
`endif
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake/status outputs are registered from the next state so that
  // they are clean flop outputs that follow the state exactly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_byte_ready <= 1'b0;
      o_ram_we     <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
`ifdef PITCH_TABLE_WRITER_CHECKSUM_EN
      o_byte_ready <= (state_n == LO) || (state_n == HI) ||
                      (state_n == CHK);
`else
      o_byte_ready <= (state_n == LO) || (state_n == HI);
`endif
      o_ram_we     <= (state_n == WR);
      o_busy       <= (state_n != IDLE);
      o_done       <= (state_n == FIN);
    end
  end

  // RAM address/data are loaded as the high byte lands, so they are
  // stable for the whole WR cycle and hold afterwards while the
  // internal word address moves on.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr       <= '0;
      lo_byte    <= '0;
      o_ram_addr <= '0;
      o_ram_data <= '0;
    end else begin
      if (state == IDLE && i_start) addr <= '0;
      if (state == LO && accept) lo_byte <= i_byte;
      if (state == HI && accept) begin
        o_ram_addr <= addr;
        o_ram_data <= {i_byte, lo_byte};
      end
      if (state == WR && addr != LAST) addr <= addr + 1'b1;
    end
  end

`ifdef PITCH_TABLE_WRITER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && i_start) begin
        csum  <= '0;
        err_q <= 1'b0;
      end
      if ((state == LO || state == HI) && accept) csum <= csum ^ i_byte;
      if (state == CHK && accept && i_byte != csum) err_q <= 1'b1;
    end
  end

  assign o_error = err_q;
`else
  assign o_error = 1'b0;
`endif

endmodule
